// File: rtl/cache_fill_fsm_pkg.sv
// Shared widths and state encoding for the cache block fill engine.
// Imported by the fill FSM and its counters.
package cache_fill_fsm_pkg;

  localparam int BLOCK_OFFSET_W = 4;
  localparam int WORD_IDX_W     = 3;
  localparam int CNT_W          = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fillState_e;

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Word counter for a block fill: clears, increments, and
// flags done once LIMIT words have been counted.
module cache_fill_counter
  import cache_fill_fsm_pkg::*;
#(
  parameter int LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign done = (count == CNT_W'(LIMIT));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: fetches one block from main memory with
// pipelined reads and streams the returned words into the data array.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LATENCY = 4,
  parameter int ADDR_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_W-1:0]     miss_address,
  input  logic                  memory_data_valid,
  input  logic [15:0]           memory_data,
  output logic                  fsm_busy,
  output logic                  mem_read_en,
  output logic [ADDR_W-1:0]     memory_address,
  output logic                  write_data_array,
  output logic [WORD_IDX_W-1:0] fill_word_idx,
  output logic [15:0]           fill_data,
  output logic                  write_tag_array
);

  localparam int TAG_W = ADDR_W - BLOCK_OFFSET_W;

  fillState_e       stateQ;
  fillState_e       stateD;
  logic [TAG_W-1:0] baseQ;
  logic [CNT_W-1:0] issueCnt;
  logic [CNT_W-1:0] recvCnt;
  logic             issueDone;
  logic             recvDone;
  logic             inFill;
  logic             idleMiss;
  logic             issueEn;
  logic             recvEn;
  logic             lastRecv;
  logic             cntClear;
  logic             unusedBits;

  // Offset bits are implied by the word counter; latency only
  // shapes when responses arrive, not the control here.
  assign unusedBits = ^{miss_address[BLOCK_OFFSET_W-1:0],
                        issueCnt[CNT_W-1], 1'(MEM_LATENCY)};

  assign inFill   = (stateQ == ST_FILL);
  assign idleMiss = (stateQ == ST_IDLE) && miss_detected;
  assign issueEn  = inFill && !issueDone;
  assign recvEn   = inFill && memory_data_valid && !recvDone;
  assign lastRecv = recvEn &&
                    (recvCnt == CNT_W'(BLOCK_WORDS - 1));
  assign cntClear = !inFill || lastRecv;

  cache_fill_counter #(
    .LIMIT (BLOCK_WORDS)
  ) u_issueCnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cntClear),
    .inc   (issueEn),
    .count (issueCnt),
    .done  (issueDone)
  );

  cache_fill_counter #(
    .LIMIT (BLOCK_WORDS)
  ) u_recvCnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cntClear),
    .inc   (recvEn),
    .count (recvCnt),
    .done  (recvDone)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= ST_IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baseQ <= '0;
    end else if (idleMiss) begin
      baseQ <= miss_address[ADDR_W-1:BLOCK_OFFSET_W];
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      ST_IDLE: if (miss_detected) stateD = ST_FILL;
      ST_FILL: if (lastRecv)      stateD = ST_IDLE;
      default: stateD = ST_IDLE;
    endcase
  end

  always_comb begin
    fsm_busy         = inFill || idleMiss;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word_idx    = '0;
    fill_data        = '0;
    write_tag_array  = lastRecv;
    if (issueEn) begin
      mem_read_en    = 1'b1;
      memory_address = {baseQ,
                        issueCnt[WORD_IDX_W-1:0],
                        1'b0};
    end
    if (recvEn) begin
      write_data_array = 1'b1;
      fill_word_idx    = recvCnt[WORD_IDX_W-1:0];
      fill_data        = memory_data;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a fixed-latency
// memory model answering each read four cycles later.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  fill_word_idx;
  logic [15:0] fill_data;
  logic        write_tag_array;

  logic        injV;
  logic [15:0] injD;

  logic        p0V = 1'b0;
  logic        p1V = 1'b0;
  logic        p2V = 1'b0;
  logic        modelV = 1'b0;
  logic [15:0] p0A = '0;
  logic [15:0] p1A = '0;
  logic [15:0] p2A = '0;
  logic [15:0] modelD = '0;

  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  cache_fill_fsm u_dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .fill_word_idx     (fill_word_idx),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array)
  );

  function automatic logic [15:0] dataOf(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // Read sampled at edge N returns valid data in the cycle after edge N+3.
  always @(posedge clk) begin
    p0V    <= mem_read_en;
    p0A    <= memory_address;
    p1V    <= p0V;
    p1A    <= p0A;
    p2V    <= p1V;
    p2A    <= p1A;
    modelV <= p2V;
    modelD <= dataOf(p2A);
  end

  assign memory_data_valid = modelV | injV;
  assign memory_data       = injV ? injD : modelD;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkIdle(input string nm);
    chk({nm, " busy"}, 16'(fsm_busy), 16'd0);
    chk({nm, " rd"},   16'(mem_read_en), 16'd0);
    chk({nm, " wda"},  16'(write_data_array), 16'd0);
    chk({nm, " tag"},  16'(write_tag_array), 16'd0);
  endtask

  // Cycle 0 presents the miss; reads in 1..8; writes in 5..12.
  task automatic expCycle(input int c,
                          input logic [15:0] base,
                          input string nm);
    logic        rdE;
    logic        wrE;
    string       t;
    t   = $sformatf("%s c%0d", nm, c);
    rdE = (c >= 1) && (c <= 8);
    wrE = (c >= 5) && (c <= 12);
    chk({t, " busy"}, 16'(fsm_busy), 16'd1);
    chk({t, " rd"}, 16'(mem_read_en), 16'(rdE));
    if (rdE)
      chk({t, " addr"}, memory_address,
          base + 16'(2 * (c - 1)));
    chk({t, " wda"}, 16'(write_data_array), 16'(wrE));
    if (wrE) begin
      chk({t, " idx"}, 16'(fill_word_idx), 16'(c - 5));
      chk({t, " data"}, fill_data,
          dataOf(base + 16'(2 * (c - 5))));
    end
    chk({t, " tag"}, 16'(write_tag_array), 16'(c == 12));
  endtask

  task automatic runFill(input logic [15:0] missA,
                         input logic [15:0] base,
                         input int lastC,
                         input string nm);
    for (int c = 0; c <= lastC; c++) begin
      tick();
      miss_detected = 1'b1;
      miss_address  = (c == 0) ? missA : (16'hF00F ^ 16'(c));
      #1;
      expCycle(c, base, nm);
    end
  endtask

  initial begin
    rst           = 1'b1;
    miss_detected = 1'b0;
    miss_address  = '0;
    injV          = 1'b0;
    injD          = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chkIdle("reset");
    chk("reset addr", memory_address, 16'h0000);
    chk("reset idx", 16'(fill_word_idx), 16'd0);
    chk("reset data", fill_data, 16'h0000);

    tick();
    injV = 1'b1;
    injD = 16'hBEEF;
    #1;
    chkIdle("spurious");
    tick();
    injV = 1'b0;

    runFill(16'h1236, 16'h1230, 12, "basic");
    tick();
    miss_detected = 1'b0;
    injV          = 1'b1;
    injD          = 16'h1234;
    #1;
    chkIdle("after basic");
    tick();
    injV = 1'b0;
    #1;
    chkIdle("excess");

    runFill(16'h002A, 16'h0020, 12, "b2b first");
    runFill(16'h0040, 16'h0040, 12, "b2b second");
    tick();
    miss_detected = 1'b0;
    #1;
    chkIdle("after b2b");

    runFill(16'h345C, 16'h3450, 5, "pre-reset");
    tick();
    rst           = 1'b1;
    miss_detected = 1'b0;
    #1;
    chk("rst cycle tag", 16'(write_tag_array), 16'd0);
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      chkIdle($sformatf("post-reset k%0d", k));
      tick();
    end

    runFill(16'h00A2, 16'h00A0, 12, "restart");
    tick();
    miss_detected = 1'b0;
    #1;
    chkIdle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nErr);
    $finish;
  end

endmodule
